// File: rtl/ysyx_22041752_mem_arb.sv
// Two-requester arbiter sharing one single-outstanding memory port between IFU and LSU.
// Optional performance counters enabled by defining YSYX_22041752_ARB_PERF_EN.
module ysyx_22041752_mem_arb #(
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_en,
  input  logic [ADDR_WD-1:0]   inst_addr,
  output logic                 inst_ready,
  output logic [DATA_WD-1:0]   inst_rdata,
  output logic                 inst_valid,
  input  logic                 data_en,
  input  logic                 data_wen,
  input  logic [ADDR_WD-1:0]   data_addr,
  input  logic [DATA_WD-1:0]   data_wdata,
  input  logic [DATA_WD/8-1:0] data_wmask,
  output logic                 data_ready,
  output logic [DATA_WD-1:0]   data_rdata,
  output logic                 data_valid,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_WD-1:0]   mem_addr,
  output logic [DATA_WD-1:0]   mem_wdata,
  output logic [DATA_WD/8-1:0] mem_wstrb,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DATA_WD-1:0]   mem_rdata
`ifdef YSYX_22041752_ARB_PERF_EN
  ,
  output logic [63:0]          perf_if_cnt,
  output logic [63:0]          perf_ls_cnt,
  output logic [63:0]          perf_conflict_cnt
`endif
);

  localparam int unsigned STRB_WD  = DATA_WD / 8;
  localparam logic        OWNER_IF = 1'b0;
  localparam logic        OWNER_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q;
  logic [ADDR_WD-1:0]   addr_q;
  logic                 we_q;
  logic [DATA_WD-1:0]   wdata_q;
  logic [STRB_WD-1:0]   wstrb_q;
  logic                 inst_acc;
  logic                 data_acc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, handshakes and response routing; nothing is accepted or reported during reset
  always_comb begin
    state_d    = state_q;
    inst_ready = 1'b0;
    data_ready = 1'b0;
    inst_valid = 1'b0;
    data_valid = 1'b0;
    mem_req    = 1'b0;
    inst_acc   = 1'b0;
    data_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        data_ready = !reset;
        inst_ready = !reset && !data_en;
        data_acc   = data_en && data_ready;
        inst_acc   = inst_en && inst_ready;
        if (data_acc || inst_acc) state_d = REQ;
      end
      REQ: begin
        mem_req = !reset;
        if (mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (mem_rvalid && !reset) begin
          inst_valid = (owner_q == OWNER_IF);
          data_valid = (owner_q == OWNER_LS);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request registers: captured only on the accept cycle, LSU has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWNER_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (data_acc) begin
      owner_q <= OWNER_LS;
      addr_q  <= data_addr;
      we_q    <= data_wen;
      wdata_q <= data_wdata;
      wstrb_q <= data_wen ? data_wmask : STRB_WD'(0);
    end else if (inst_acc) begin
      owner_q <= OWNER_IF;
      addr_q  <= inst_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

`ifdef YSYX_22041752_ARB_PERF_EN
  logic conflict;
  assign conflict = inst_en && !inst_ready && (state_q == IDLE);

  // Free-running event counters, wrapping modulo 2^64
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_cnt       <= '0;
      perf_ls_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (inst_acc) perf_if_cnt       <= perf_if_cnt + 64'd1;
      if (data_acc) perf_ls_cnt       <= perf_ls_cnt + 64'd1;
      if (conflict) perf_conflict_cnt <= perf_conflict_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041752_mem_arb.sv
// Scoreboard bench for ysyx_22041752_mem_arb: directed transactions, responses checked by a monitor.
module tb_ysyx_22041752_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [63:0] inst_rdata;
  logic        inst_valid;
  logic        data_en;
  logic        data_wen;
  logic [31:0] data_addr;
  logic [63:0] data_wdata;
  logic [7:0]  data_wmask;
  logic        data_ready;
  logic [63:0] data_rdata;
  logic        data_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
`ifdef YSYX_22041752_ARB_PERF_EN
  logic [63:0] perf_if_cnt, perf_ls_cnt, perf_conflict_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_22041752_mem_arb #(.ADDR_WD(32), .DATA_WD(64)) dut (
    .clk(clk), .reset(reset),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wmask(data_wmask), .data_ready(data_ready),
    .data_rdata(data_rdata), .data_valid(data_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef YSYX_22041752_ARB_PERF_EN
    , .perf_if_cnt(perf_if_cnt), .perf_ls_cnt(perf_ls_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  typedef struct packed {
    logic        is_data;
    logic        chk_data;
    logic [63:0] rdata;
  } resp_t;

  resp_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    n_if = 0, n_ls = 0, n_conf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every valid pulse must match the oldest expected response
  always @(negedge clk) begin
    if (inst_valid || data_valid) begin
      resp_t e;
      if (inst_valid && data_valid) chk("both_valid", 1'b1, 1'b0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", {inst_valid, data_valid}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("resp_owner", {inst_valid, data_valid}, e.is_data ? 2'b01 : 2'b10);
        if (e.chk_data)
          chk("resp_rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
      end
    end
  end

  // One full transaction; returns at posedge+1 of the first IDLE cycle after the response
  task automatic txn(input bit is_data, input bit wen, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wmask,
                     input int gnt_dly, input logic [63:0] rdata);
    resp_t e;
    logic [7:0] exp_strb;
    exp_strb = (is_data && wen) ? wmask : 8'h00;
    if (is_data) begin
      if (inst_en) n_conf++;
      data_en = 1'b1; data_wen = wen; data_addr = addr;
      data_wdata = wdata; data_wmask = wmask;
    end else begin
      inst_en = 1'b1; inst_addr = addr;
    end
    @(negedge clk);
    chk("data_ready_idle", data_ready, 1'b1);
    chk("inst_ready_idle", inst_ready, !is_data);
    tick();
    if (is_data) begin
      n_ls++;
      data_en = 1'b0; data_addr = ~addr; data_wdata = ~wdata; data_wmask = ~wmask; data_wen = !wen;
    end else begin
      n_if++;
      inst_en = 1'b0; inst_addr = ~addr;
    end
    for (int i = 0; i <= gnt_dly; i++) begin
      mem_gnt = (i == gnt_dly);
      @(negedge clk);
      chk("req_mem_req", mem_req, 1'b1);
      chk("req_mem_addr", mem_addr, addr);
      chk("req_mem_we", mem_we, is_data && wen);
      chk("req_mem_wstrb", mem_wstrb, exp_strb);
      if (is_data && wen) chk("req_mem_wdata", mem_wdata, wdata);
      chk("req_no_ready", {inst_ready, data_ready}, 2'b00);
      tick();
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = rdata;
    e.is_data = is_data;
    e.chk_data = !(is_data && wen);
    e.rdata = rdata;
    sb.push_back(e);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = 64'h0;
    chk("resp_taken", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    inst_en = 1'b1; inst_addr = 32'h1234_5678;
    data_en = 1'b1; data_wen = 1'b1; data_addr = 32'h0; data_wdata = 64'h0; data_wmask = 8'hFF;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", {inst_ready, data_ready}, 2'b00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wstrb", mem_wstrb, 8'h00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    inst_en = 1'b0; data_en = 1'b0; data_wen = 1'b0; data_wmask = 8'h00;
    tick();
    reset = 1'b0;
    tick();

    // IFU-only read, minimum latency, then ready returns
    txn(1'b0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 0, 64'h0000_0013_0000_0093);
    @(negedge clk);
    chk("if_ready_after", inst_ready, 1'b1);
    tick();

    // Contention: LSU read wins, IFU accepted right after with its own address
    inst_en = 1'b1; inst_addr = 32'h8000_0040;
    txn(1'b1, 1'b0, 32'h8000_1000, 64'h0, 8'hFF, 0, 64'h1111_2222_3333_4444);
    txn(1'b0, 1'b0, 32'h8000_0040, 64'h0, 8'h00, 1, 64'h0000_0517_0000_0297);

    // Write with 5 cycles of grant backpressure
    txn(1'b1, 1'b1, 32'h8000_2000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 5, 64'h5555_AAAA_5555_AAAA);
    @(negedge clk);
    chk("wr_ready_after", {inst_ready, data_ready}, 2'b11);
    tick();

    // Reset while waiting for the response, then a late stray response
    data_en = 1'b1; data_wen = 1'b0; data_addr = 32'h8000_3000; data_wmask = 8'h00;
    tick();
    data_en = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset = 1'b1;
    n_if = 0; n_ls = 0; n_conf = 0;
    tick();
    @(negedge clk);
    chk("midrst_ready", {inst_ready, data_ready}, 2'b00);
    chk("midrst_mem_req", mem_req, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    chk("postrst_mem_req", mem_req, 1'b0);
    chk("postrst_ready", {inst_ready, data_ready}, 2'b11);
    tick();
    mem_rvalid = 1'b0;

    // Stray response in IDLE
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    chk("stray_ready", {inst_ready, data_ready}, 2'b11);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_idle_req", mem_req, 1'b0);
    chk("stray_idle_ready", data_ready, 1'b1);
    tick();

    // Post-reset traffic: IFU reads and a contended LSU read
    txn(1'b0, 1'b0, 32'h8000_0100, 64'h0, 8'h00, 2, 64'h0123_4567_89AB_CDEF);
    inst_en = 1'b1; inst_addr = 32'h8000_0104;
    txn(1'b1, 1'b0, 32'h8000_4008, 64'h0, 8'h00, 0, 64'hFEDC_BA98_7654_3210);
    txn(1'b0, 1'b0, 32'h8000_0104, 64'h0, 8'h00, 0, 64'h0000_0000_0000_0001);
    tick();

`ifdef YSYX_22041752_ARB_PERF_EN
    @(negedge clk);
    chk("perf_if_cnt", perf_if_cnt, 64'(n_if));
    chk("perf_ls_cnt", perf_ls_cnt, 64'(n_ls));
    chk("perf_conflict_cnt", perf_conflict_cnt, 64'(n_conf));
`endif
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
